pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the CPU fetch stage. It generalises the fixed 4-bit + 2-bit PC increment adder into a registered PC with:
- configurable width and increment step
- signed PC-relative branch and absolute jump redirects
- valid/ready handshake to instruction fetch
- run/halt state machine

It sits between the control unit (branch/jump decisions) and the instruction memory address port.

Parameters:
- PC_W, 12, PC width in bits.
- INC, 1, sequential increment step; unsigned, 1 to 2^PC_W-1.
- OFF_W, 8, width of the signed branch offset; OFF_W <= PC_W.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN; power of two, >= 2.

Ports:
- clk, in, 1, clock, rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- halt_req, in, 1, request to enter HALT.
- resume, in, 1, leave HALT.
- br_take, in, 1, take PC-relative branch this cycle.
- br_off, in, OFF_W, signed two's-complement branch offset.
- jmp_take, in, 1, take absolute jump this cycle.
- jmp_addr, in, PC_W, jump target.
- fetch_ready, in, 1, fetch stage accepts the current pc.
- fetch_valid, out, 1, pc is valid for fetch.
- pc, out, PC_W, current program counter.
- wrap, out, 1, one-cycle pulse when a sequential increment wrapped past 2^PC_W-1.
- halted, out, 1, high in HALT state.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values while rst_n=0:
  - state=BOOT, pc=RESET_PC
  - fetch_valid=0, wrap=0, halted=0
  - RAS empty
- State BOOT: one cycle, fetch_valid=0, pc holds. Always goes to RUN on the next edge; all inputs are ignored.
- State RUN: fetch_valid=1. A fire is fetch_valid & fetch_ready. Next-pc priority, evaluated each cycle:
  1. jmp_take -> jmp_addr
  2. br_take -> pc + sign_extend(br_off), modulo 2^PC_W
  3. (PC_RAS_EN) ret with RAS non-empty -> RAS top
  4. fire -> pc + INC, modulo 2^PC_W
  5. otherwise hold pc
- Redirects (priorities 1-3) are accepted whether or not fetch_ready is high. An unaccepted pc is discarded (flush). pc updates on the next edge, so latency is 1 cycle.
- wrap: registered. Pulses for exactly one cycle, the cycle after a fire taken with the sequential path only (no redirect) where pc + INC carried out of PC_W bits. Never asserted on a redirect, even if the redirect target arithmetic overflows.
- halt_req in RUN -> HALT on the next edge; a redirect in the same cycle is still applied to pc.
- State HALT: fetch_valid=0, halted=1, pc holds. br_take, jmp_take and ret are ignored.
  - resume=1 -> RUN on the next edge.
  - halt_req and resume both high -> stay in HALT.
- Asynchronous reset mid-operation (any state, any pending redirect) returns to the reset values immediately; the pending redirect is lost.
- fetch_valid must not drop in RUN while fetch_ready=0, except on a halt_req transition.
- pc is stable whenever fetch_valid=1 and fetch_ready=0, unless a redirect is taken that cycle.

Optional Feature:
- Macro PC_RAS_EN.
- Defined:
  - Adds inputs call (1) and ret (1), and outputs ras_empty (1) and ras_full (1).
  - call is valid only with jmp_take. It pushes pc + INC (modulo 2^PC_W) onto a RAS_DEPTH-entry circular stack.
  - Pushing when full overwrites the oldest entry; ras_full stays 1.
  - ret with the RAS non-empty pops and redirects to the popped value at priority 3.
  - ret with the RAS empty is ignored; pc follows the sequential/hold rule.
  - call and ret in the same cycle: the jump and push occur, and ret is ignored with no pop.
  - In HALT the stack is frozen.
- Not defined: the ports and stack logic are absent; priority 3 does not exist.

Test Plan:
1. Reset release, fetch_ready=1 constantly -> 1 BOOT cycle with fetch_valid=0. Then pc = 0, 1, 2, 3, ...; fetch_valid=1 from the 2nd cycle after release.
2. PC_W=4, INC=2, start pc=14, fire -> pc=0 on the next edge; wrap=1 for one cycle only.
3. pc=0x020, fetch_ready=0, br_take with br_off=-4 (0xFC) -> pc=0x01C next cycle. Simultaneous jmp_take with jmp_addr=0x100 overrides the branch -> pc=0x100.
4. halt_req at pc=5 together with jmp_take to 0x40 -> pc=0x40, halted=1, fetch_valid=0. br_take in HALT is ignored. resume -> fetch resumes at 0x40.
5. Assert rst_n=0 asynchronously mid-RUN with br_take high -> pc=RESET_PC and fetch_valid=0 immediately, without waiting for a clock edge.
6. (PC_RAS_EN, RAS_DEPTH=4) Five call+jmp from pcs 1..5, then five ret:
   - first four rets return to 6, 5, 4, 3 (the push from pc 1 was overwritten)
   - fifth ret is ignored, pc increments
   - ras_empty=1 after the fourth ret

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program counter for the fetch stage: sequential increment, branch/jump redirects,
// valid/ready fetch handshake and a BOOT/RUN/HALT state machine. Optional return-address stack: PC_RAS_EN.
module pc_sequencer #(
  parameter int              PC_W      = 12,
  parameter int unsigned     INC       = 1,
  parameter int              OFF_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             br_take,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jmp_take,
  input  logic [PC_W-1:0]  jmp_addr,
`ifdef PC_RAS_EN
  input  logic             call,
  input  logic             ret,
  output logic             ras_empty,
  output logic             ras_full,
`endif
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [PC_W-1:0]  pc,
  output logic             wrap,
  output logic             halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            wrap_nxt;
  logic [PC_W-1:0] off_ext;
  logic [PC_W:0]   inc_sum;
  logic            fire;

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);
  assign fire        = fetch_valid & fetch_ready;
  assign off_ext     = PC_W'($signed(br_off));
  // The extra top bit of the sum is the carry that drives wrap.
  assign inc_sum     = {1'b0, pc} + (PC_W+1)'(INC);

`ifdef PC_RAS_EN
  localparam int RAS_AW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_top, ras_top_inc;
  logic [RAS_AW:0]   ras_cnt;
  logic              ras_push, ras_pop;

  assign ras_top_inc = ras_top + RAS_AW'(1);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == (RAS_AW+1)'(RAS_DEPTH));
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    pc_nxt    = pc;
    wrap_nxt  = 1'b0;
`ifdef PC_RAS_EN
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
`endif
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (jmp_take) begin
          pc_nxt = jmp_addr;
`ifdef PC_RAS_EN
          ras_push = call;
`endif
        end else if (br_take) begin
          pc_nxt = pc + off_ext;
`ifdef PC_RAS_EN
        end else if (ret && !ras_empty) begin
          pc_nxt  = ras_mem[ras_top];
          ras_pop = 1'b1;
`endif
        end else if (fire) begin
          pc_nxt   = inc_sum[PC_W-1:0];
          wrap_nxt = inc_sum[PC_W];
        end
        if (halt_req) state_nxt = HALT;
      end
      HALT: if (resume && !halt_req) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      wrap  <= wrap_nxt;
    end
  end

`ifdef PC_RAS_EN
  // The circular top pointer makes a push on a full stack land on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_top <= ras_top_inc;
      if (!ras_full) ras_cnt <= ras_cnt + (RAS_AW+1)'(1);
    end else if (ras_pop) begin
      ras_top <= ras_top - RAS_AW'(1);
      ras_cnt <= ras_cnt - (RAS_AW+1)'(1);
    end
  end

  // NOTE: stack storage is not reset; the count marks which entries hold live data.
  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top_inc] <= inc_sum[PC_W-1:0];
  end
`endif

endmodule
